// File: rtl/vector_classify_sequencer.sv
// Multi-cycle front end for the combinational vfclass.v unit: accepts a full-VLEN request,
// feeds the unit one SLICE_WIDTH slice per cycle and returns the reassembled result.
module vector_classify_sequencer #(
  parameter int VLEN        = 128,
  parameter int SLICE_WIDTH = 64,
  parameter int EV_WIDTH    = 32   // width of the opaque execution_vector_t descriptor
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [EV_WIDTH-1:0]    req_execution_vector,
  input  logic [VLEN-1:0]        req_vs2,
  output logic [EV_WIDTH-1:0]    unit_execution_vector,
  output logic [SLICE_WIDTH-1:0] unit_vs2,
  input  logic [SLICE_WIDTH-1:0] unit_vd,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [VLEN-1:0]        resp_vd,
  output logic                   busy
);

  localparam int NUM_SLICES = VLEN / SLICE_WIDTH;
  localparam int CNT_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NUM_SLICES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [EV_WIDTH-1:0]  ev_q, ev_d;
  logic [VLEN-1:0]      vs2_q, vs2_d;
  logic [VLEN-1:0]      vd_q, vd_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 accept;

  logic [SLICE_WIDTH-1:0] vs2_slices [NUM_SLICES];

  for (genvar gi = 0; gi < NUM_SLICES; gi++) begin : g_slice
    assign vs2_slices[gi] = vs2_q[gi*SLICE_WIDTH +: SLICE_WIDTH];
  end

  // A response handshake frees the block in the same cycle, so a new request may ride on it.
  assign req_ready = ~flush & ((state_q == IDLE) | ((state_q == RESPOND) & resp_ready));
  assign accept    = req_valid & req_ready;

  always_comb begin
    state_d = state_q;
    ev_d    = ev_q;
    vs2_d   = vs2_q;
    vd_d    = vd_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = ISSUE;
      end
      ISSUE: begin
        for (int i = 0; i < NUM_SLICES; i++) begin
          if (cnt_q == CNT_W'(i)) vd_d[i*SLICE_WIDTH +: SLICE_WIDTH] = unit_vd;
        end
        if (cnt_q == LAST_SLICE) state_d = RESPOND;
        else                     cnt_d   = cnt_q + 1'b1;
      end
      RESPOND: begin
        if (resp_ready) state_d = accept ? ISSUE : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      ev_d  = req_execution_vector;
      vs2_d = req_vs2;
      vd_d  = '0;
      cnt_d = '0;
    end
    // Flush overrides every handshake and leaves the partial result untouched.
    if (flush) begin
      state_d = IDLE;
      vd_d    = vd_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      ev_q    <= '0;
      vs2_q   <= '0;
      vd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ev_q    <= ev_d;
      vs2_q   <= vs2_d;
      vd_q    <= vd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign unit_execution_vector = ev_q;
  assign unit_vs2              = (state_q == ISSUE) ? vs2_slices[cnt_q] : '0;
  assign resp_valid            = (state_q == RESPOND);
  assign resp_vd               = vd_q;
  assign busy                  = (state_q != IDLE);

endmodule

// File: tb/tb_vector_classify_sequencer.sv
// Directed bench for vector_classify_sequencer, with a behavioural vfclass unit on unit_*.
// Execution vector bits [1:0] encode SEW for the unit model: 1=16, 2=32, 3=64.
module tb_vector_classify_sequencer;

  localparam int VLEN = 128;
  localparam int SW   = 64;
  localparam int EVW  = 32;

  logic            clock = 1'b0;
  logic            reset, flush, req_valid, resp_ready;
  logic            req_ready, resp_valid, busy;
  logic [EVW-1:0]  req_execution_vector, unit_execution_vector;
  logic [VLEN-1:0] req_vs2, resp_vd;
  logic [SW-1:0]   unit_vs2, unit_vd;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  vector_classify_sequencer #(.VLEN(VLEN), .SLICE_WIDTH(SW), .EV_WIDTH(EVW)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_execution_vector(req_execution_vector), .req_vs2(req_vs2),
    .unit_execution_vector(unit_execution_vector), .unit_vs2(unit_vs2), .unit_vd(unit_vd),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_vd(resp_vd), .busy(busy)
  );

  function automatic logic [9:0] cls(input logic sgn, input logic e_ones, input logic e_zero,
                                     input logic m_zero, input logic m_msb);
    logic [9:0] r;
    r = '0;
    if (e_ones) begin
      if (m_zero) r[sgn ? 0 : 7] = 1'b1;
      else        r[m_msb ? 9 : 8] = 1'b1;
    end else if (e_zero) begin
      if (m_zero) r[sgn ? 3 : 4] = 1'b1;
      else        r[sgn ? 2 : 5] = 1'b1;
    end else begin
      r[sgn ? 1 : 6] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [63:0] classify_slice(input logic [63:0] s, input logic [1:0] sew);
    logic [63:0] r;
    logic [31:0] w;
    logic [15:0] h;
    r = '0;
    if (sew == 2'd3) begin
      r = {54'b0, cls(s[63], &s[62:52], ~|s[62:52], ~|s[51:0], s[51])};
    end else if (sew == 2'd2) begin
      for (int e = 0; e < 2; e++) begin
        w = s[e*32 +: 32];
        r[e*32 +: 32] = {22'b0, cls(w[31], &w[30:23], ~|w[30:23], ~|w[22:0], w[22])};
      end
    end else begin
      for (int e = 0; e < 4; e++) begin
        h = s[e*16 +: 16];
        r[e*16 +: 16] = {6'b0, cls(h[15], &h[14:10], ~|h[14:10], ~|h[9:0], h[9])};
      end
    end
    return r;
  endfunction

  always_comb unit_vd = classify_slice(unit_vs2, unit_execution_vector[1:0]);

  typedef struct {
    string           name;
    logic [EVW-1:0]  ev;
    logic [VLEN-1:0] vs2;
    logic [VLEN-1:0] exp_vd;
  } vec_t;

  vec_t tbl [5];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_txn(input int idx);
    req_execution_vector = tbl[idx].ev;
    req_vs2   = tbl[idx].vs2;
    req_valid = 1'b1;
    #1;
    chk({tbl[idx].name, " req_ready"}, {127'b0, req_ready}, 128'd1);
    step();
    req_valid = 1'b0;
    chk({tbl[idx].name, " unit_ev"}, {96'b0, unit_execution_vector}, {96'b0, tbl[idx].ev});
    chk({tbl[idx].name, " resp_valid_early"}, {127'b0, resp_valid}, 128'd0);
    step();
    chk({tbl[idx].name, " resp_valid_mid"}, {127'b0, resp_valid}, 128'd0);
    step();
    chk({tbl[idx].name, " resp_valid"}, {127'b0, resp_valid}, 128'd1);
    chk({tbl[idx].name, " resp_vd"}, resp_vd, tbl[idx].exp_vd);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk({tbl[idx].name, " idle_after"}, {126'b0, busy, resp_valid}, 128'd0);
    $display("txn %s vs2=%h resp_vd=%h", tbl[idx].name, tbl[idx].vs2, tbl[idx].exp_vd);
  endtask

  initial begin
    int accepted, got, illegal, cycles;
    logic [VLEN-1:0] exp_q[$];
    logic [VLEN-1:0] nvs2;
    logic [1:0]      nsew;
    logic            acc, hs;

    tbl[0] = '{"sew64_inf_negzero", 32'd3,
               {64'h7FF0000000000000, 64'h8000000000000000},
               {64'h80, 64'h08}};
    tbl[1] = '{"sew32_mix", 32'd2,
               {32'h7FC00000, 32'h3F800000, 32'h00000001, 32'hFF800000},
               {32'h200, 32'h40, 32'h20, 32'h01}};
    tbl[2] = '{"sew16_all", 32'd1,
               {16'h7C00, 16'h0000, 16'h8001, 16'hC000, 16'h7E00, 16'h7C01, 16'hFC00, 16'h3C00},
               {16'h0080, 16'h0010, 16'h0004, 16'h0002, 16'h0200, 16'h0100, 16'h0001, 16'h0040}};
    tbl[3] = '{"sew64_qnan_sub", 32'd3,
               {64'hFFF8000000000000, 64'h000FFFFFFFFFFFFF},
               {64'h200, 64'h20}};
    tbl[4] = '{"sew32_zero_snan", 32'd2,
               {32'h80000000, 32'h00000000, 32'h7F800001, 32'hBF800000},
               {32'h08, 32'h10, 32'h100, 32'h02}};

    reset = 1'b1; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    req_execution_vector = '0; req_vs2 = '0;
    step();
    step();
    reset = 1'b0;
    #1;
    chk("rst req_ready", {127'b0, req_ready}, 128'd1);
    chk("rst resp_valid", {127'b0, resp_valid}, 128'd0);
    chk("rst resp_vd", resp_vd, '0);
    chk("rst unit_vs2", {64'b0, unit_vs2}, '0);
    chk("rst unit_ev", {96'b0, unit_execution_vector}, '0);
    chk("rst busy", {127'b0, busy}, 128'd0);

    for (int i = 0; i < 5; i++) run_txn(i);

    // Stall in RESPOND, then back-to-back accept on the response handshake.
    req_execution_vector = tbl[0].ev; req_vs2 = tbl[0].vs2; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    step();
    chk("stall resp_valid", {127'b0, resp_valid}, 128'd1);
    req_execution_vector = tbl[1].ev; req_vs2 = tbl[1].vs2; req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("stall req_ready", {127'b0, req_ready}, 128'd0);
      chk("stall resp_vd", resp_vd, tbl[0].exp_vd);
      chk("stall resp_valid_hold", {127'b0, resp_valid}, 128'd1);
      step();
    end
    resp_ready = 1'b1;
    #1;
    chk("b2b req_ready", {127'b0, req_ready}, 128'd1);
    step();
    req_valid = 1'b0; resp_ready = 1'b0;
    chk("b2b issue", {126'b0, busy, resp_valid}, 128'd2);
    step();
    chk("b2b resp_valid_mid", {127'b0, resp_valid}, 128'd0);
    step();
    chk("b2b resp_valid", {127'b0, resp_valid}, 128'd1);
    chk("b2b resp_vd", resp_vd, tbl[1].exp_vd);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    $display("txn stall_b2b second resp_vd=%h", tbl[1].exp_vd);

    // Flush during ISSUE slice 1.
    req_execution_vector = tbl[2].ev; req_vs2 = tbl[2].vs2; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    chk("flush slice0", {64'b0, unit_vs2}, {64'b0, tbl[2].vs2[63:0]});
    step();
    chk("flush slice1", {64'b0, unit_vs2}, {64'b0, tbl[2].vs2[127:64]});
    flush = 1'b1;
    #1;
    chk("flush req_ready", {127'b0, req_ready}, 128'd0);
    step();
    flush = 1'b0;
    chk("flush busy", {127'b0, busy}, 128'd0);
    chk("flush unit_vs2", {64'b0, unit_vs2}, '0);
    for (int c = 0; c < 3; c++) begin
      chk("flush no_resp", {127'b0, resp_valid}, 128'd0);
      step();
    end
    $display("txn flush_in_issue done");
    run_txn(3);

    // Reset while holding a response.
    req_execution_vector = tbl[4].ev; req_vs2 = tbl[4].vs2; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    step();
    chk("rstresp resp_valid_pre", {127'b0, resp_valid}, 128'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("rstresp resp_valid", {127'b0, resp_valid}, 128'd0);
    chk("rstresp resp_vd", resp_vd, '0);
    chk("rstresp req_ready", {127'b0, req_ready}, 128'd1);
    chk("rstresp unit_ev", {96'b0, unit_execution_vector}, '0);
    $display("txn reset_in_respond done");
    step();

    // Randomised requests held valid while busy; one response per accept.
    accepted = 0; got = 0; illegal = 0; cycles = 0;
    nsew = 2'($urandom_range(1, 3));
    nvs2 = {$urandom, $urandom, $urandom, $urandom};
    while (got < 20 && cycles < 2000) begin
      req_valid = (accepted < 20);
      req_execution_vector = {30'b0, nsew};
      req_vs2 = nvs2;
      resp_ready = 1'($urandom_range(0, 1));
      #1;
      acc = req_valid && req_ready;
      hs  = resp_valid && resp_ready;
      if (acc && busy && !hs) illegal++;
      if (hs) begin
        if (exp_q.size() == 0) begin
          chk("rand spurious_resp", resp_vd, ~resp_vd);
        end else begin
          chk("rand resp_vd", resp_vd, exp_q.pop_front());
        end
        got++;
        $display("txn rand resp %0d vd=%h", got, resp_vd);
      end
      if (acc) begin
        exp_q.push_back({classify_slice(nvs2[127:64], nsew), classify_slice(nvs2[63:0], nsew)});
        accepted++;
        nsew = 2'($urandom_range(1, 3));
        nvs2 = {$urandom, $urandom, $urandom, $urandom};
      end
      step();
      cycles++;
    end
    req_valid = 1'b0; resp_ready = 1'b0;
    chk("rand accepted", 128'(accepted), 128'd20);
    chk("rand responses", 128'(got), 128'd20);
    chk("rand illegal_accept", 128'(illegal), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
